// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 scan-code constants, decoder state enum and key-map helpers.
package ps2_pkg;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERRF   = 8'hFF;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_JUMP   = 8'h29;
  localparam logic [7:0] SC_RETRY  = 8'h2D;
  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_e;
  // Bytes that IDLE consumes without decoding a key: prefixes and receiver chatter.
  function automatic logic idle_skip(input logic [7:0] code);
    idle_skip = code == SC_EXT || code == SC_BRK || code == SC_PAUSE ||
                code == SC_BAT || code == SC_ACK || code == SC_RESEND;
  endfunction
  // One-hot {retry, jump, right, left}; jump and retry have no extended form.
  function automatic logic [3:0] key_mask(input logic [7:0] code, input logic ext);
    key_mask = {code == SC_RETRY && !ext, code == SC_JUMP && !ext, code == SC_RIGHT, code == SC_LEFT};
  endfunction
endpackage

// File: rtl/ps2_rise_pulse.sv
// ps2_rise_pulse: registered 0->1 detector fed with a level's next-state value.
module ps2_rise_pulse (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic pulse_o
);
  logic prev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      pulse_o <= 1'b0;
    end else begin
      prev_q  <= level_i;
      pulse_o <= level_i & ~prev_q;
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: parses E0/F0/E1 scan-code sequences into held key levels and press pulses.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TMR_W          = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       left,
  output logic       right,
  output logic       jump,
  output logic       retry,
  output logic       jump_press,
  output logic       retry_press,
  output logic       seq_err
);
  state_e           state_q;
  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pause_q;
  logic [3:0]       lvl_q, lvl_d, mask;
  logic             err_q, is_err, timeout, ext_now, mk, act;
  always_comb begin
    is_err  = rx_valid && (rx_byte == SC_ERR0 || rx_byte == SC_ERRF);
    timeout = !rx_valid && state_q != S_IDLE && cnt_q == TMR_W'(TIMEOUT_CYCLES - 1);
    cnt_d   = (rx_valid || timeout || state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
    ext_now = state_q == S_EXT || state_q == S_EXT_BRK;
    mk      = state_q == S_IDLE || state_q == S_EXT;
    act     = rx_valid && !is_err && (state_q == S_BRK || state_q == S_EXT_BRK ||
              (state_q == S_EXT && rx_byte != SC_BRK && rx_byte != SC_EXT) ||
              (state_q == S_IDLE && !idle_skip(rx_byte)));
    mask    = key_mask(rx_byte, ext_now);
    lvl_d   = is_err ? '0 : !act ? lvl_q : mk ? (lvl_q | mask) : (lvl_q & ~mask);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pause_q <= '0;
      lvl_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      err_q <= is_err || timeout;
      if (timeout || is_err) state_q <= S_IDLE;
      else if (rx_valid) begin
        case (state_q)
          S_IDLE: begin
            if (rx_byte == SC_EXT) state_q <= S_EXT;
            else if (rx_byte == SC_BRK) state_q <= S_BRK;
            else if (rx_byte == SC_PAUSE) begin
              state_q <= S_PAUSE;
              pause_q <= 3'd7;
            end
          end
          S_EXT: state_q <= rx_byte == SC_BRK ? S_EXT_BRK : rx_byte == SC_EXT ? S_EXT : S_IDLE;
          S_PAUSE: begin
            pause_q <= pause_q - 1'b1;
            if (pause_q == 3'd1) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
  assign {retry, jump, right, left} = lvl_q;
  assign seq_err = err_q;
  ps2_rise_pulse u_jump  (.clk(clk), .rst(rst), .level_i(lvl_d[2]), .pulse_o(jump_press));
  ps2_rise_pulse u_retry (.clk(clk), .rst(rst), .level_i(lvl_d[3]), .pulse_o(retry_press));
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: random and directed scan-code streams checked against a behavioural model.
module tb_ps2_key_decoder;
  localparam int T = 40;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       left, right, jump, retry, jump_press, retry_press, seq_err;
  int         total = 0;
  int         bad = 0;
  logic [6:0] exp_q[$];
  bit         lv_left, lv_right, lv_jump, lv_retry;
  bit         pend_ext, pend_brk;
  int         pause_left, idle_run;
  always #5 clk = ~clk;
  ps2_key_decoder #(.TIMEOUT_CYCLES(T), .TMR_W(6)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .left(left), .right(right), .jump(jump), .retry(retry),
    .jump_press(jump_press), .retry_press(retry_press), .seq_err(seq_err)
  );
  function automatic void set_key(input logic [7:0] b, input bit e, input bit lvl);
    if (b == 8'h6B) lv_left = lvl;
    else if (b == 8'h74) lv_right = lvl;
    else if (b == 8'h29 && !e) lv_jump = lvl;
    else if (b == 8'h2D && !e) lv_retry = lvl;
  endfunction
  task automatic step(input bit r, input bit v, input logic [7:0] b);
    bit old_j, old_r, err;
    @(negedge clk);
    rst = r;
    rx_valid = v;
    rx_byte = b;
    old_j = lv_jump;
    old_r = lv_retry;
    err = 1'b0;
    if (r) begin
      {lv_left, lv_right, lv_jump, lv_retry, pend_ext, pend_brk} = '0;
      pause_left = 0;
      idle_run = 0;
    end else if (v) begin
      idle_run = 0;
      if (b == 8'h00 || b == 8'hFF) begin
        {lv_left, lv_right, lv_jump, lv_retry, pend_ext, pend_brk} = '0;
        pause_left = 0;
        err = 1'b1;
      end else if (pause_left > 0) pause_left--;
      else if (pend_brk) begin
        set_key(b, pend_ext, 1'b0);
        pend_ext = 1'b0;
        pend_brk = 1'b0;
      end else if (pend_ext) begin
        if (b == 8'hF0) pend_brk = 1'b1;
        else if (b != 8'hE0) begin
          set_key(b, 1'b1, 1'b1);
          pend_ext = 1'b0;
        end
      end else if (b == 8'hE0) pend_ext = 1'b1;
      else if (b == 8'hF0) pend_brk = 1'b1;
      else if (b == 8'hE1) pause_left = 7;
      else if (b != 8'hAA && b != 8'hFA && b != 8'hFE) set_key(b, 1'b0, 1'b1);
    end else if (pend_ext || pend_brk || pause_left > 0) begin
      idle_run++;
      if (idle_run == T) begin
        pend_ext = 1'b0;
        pend_brk = 1'b0;
        pause_left = 0;
        idle_run = 0;
        err = 1'b1;
      end
    end else idle_run = 0;
    exp_q.push_back({lv_left, lv_right, lv_jump, lv_retry, lv_jump & ~old_j, lv_retry & ~old_r, err});
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    step(1'b0, 1'b1, b);
    for (int i = 0; i < gap; i++) step(1'b0, 1'b0, 8'h00);
  endtask
  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i], 1);
  endtask
  always @(posedge clk) begin
    logic [6:0] e, g;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {left, right, jump, retry, jump_press, retry_press, seq_err};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL outputs t=%0t got {l,r,j,rt,jp,rp,err}=%b expected %b", $time, g, e);
      end
    end
  end
  initial begin
    logic [7:0] pool[$] = '{8'hE0, 8'hF0, 8'hE1, 8'h6B, 8'h74, 8'h29, 8'h2D, 8'h6B, 8'h29, 8'h2D,
                            8'hAA, 8'hFA, 8'hFE, 8'h12, 8'h14, 8'h77};
    int g;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    send_seq('{8'h29, 8'hF0, 8'h29});
    send_seq('{8'hE0, 8'h6B, 8'hE0, 8'h74, 8'hE0, 8'hF0, 8'h6B});
    send_seq('{8'h2D, 8'h2D, 8'h2D, 8'hF0, 8'h2D});
    send(8'hE0, T + 3);
    send(8'h29, 2);
    send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29});
    send_seq('{8'h6B, 8'h29, 8'hFF});
    send(8'hF0, 0);
    step(1'b1, 1'b0, 8'h00);
    send(8'h29, 0);
    send(8'hE1, T + 2);
    send(8'hF0, T - 2);
    send(8'h29, 0);
    send(8'hE0, 0);
    send(8'h00, 0);
    send(8'h6B, 0);
    for (int n = 0; n < 1500; n++) begin
      g = $urandom_range(0, 99);
      if (g < 2) step(1'b1, 1'b0, 8'h00);
      else if (g < 5) send($urandom_range(0, 1) ? 8'h00 : 8'hFF, 0);
      else if (g < 8) send(8'($urandom), 0);
      else send(pool[$urandom_range(0, pool.size() - 1)], g < 11 ? T + $urandom_range(0, 2) - 1 : $urandom_range(0, 2));
    end
    step(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
